// File: rtl/aes_round_engine.sv
// Iterative AES encryption engine: one shared state register walked through
// AddRoundKey / SubBytes (LANES bytes per cycle) / ShiftRows / MixColumns.
module aes_round_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_text,
    input  logic [1:0]   in_key_mode,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_text,
    output logic         busy,
    output logic [3:0]   cur_round
);

    localparam int S = 16 / LANES;
    localparam logic [3:0] STEP_LAST = 4'(S - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_round_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [2:0] {ST_IDLE, ST_ARK, ST_SUB, ST_SR, ST_MC, ST_DONE} fsm_t;

    fsm_t         fsm_r, fsm_next_s;
    logic [127:0] state_r, state_next_s;
    logic [3:0]   round_r, round_next_s;
    logic [3:0]   nr_r, nr_next_s;
    logic [3:0]   step_r, step_next_s;
    logic         in_ready_r, out_valid_r, busy_r;
    logic [7:0]   sub_in_s  [LANES];
    logic [7:0]   sub_out_s [LANES];
    int           lane_base_s;
    int           mc_col_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end else begin
                p = p;
            end
            x = xtime(x);
        end
        gf_mul = p;
    endfunction

    // Multiplicative inverse as x^254 (x^2*x^4*...*x^128), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        sbox = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
            end
        end
        shift_rows = r;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        mix_column = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // S is a power of two, so masking keeps the lane window inside the block
    // even while the shared step counter is sequencing MixColumns.
    assign lane_base_s = int'(step_r & STEP_LAST) * LANES;
    assign mc_col_s    = int'(step_r[1:0]);

    // Gather the LANES bytes addressed by the current SubBytes step.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            sub_in_s[l] = state_r[127 - 8*(lane_base_s + l) -: 8];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign sub_out_s[l] = sbox(sub_in_s[l]);
    end

    // Next-state and datapath update for the round sequencer.
    always_comb begin
        fsm_next_s   = fsm_r;
        state_next_s = state_r;
        round_next_s = round_r;
        nr_next_s    = nr_r;
        step_next_s  = step_r;
        case (fsm_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next_s = in_text;
                    fsm_next_s   = ST_ARK;
                    case (in_key_mode)
                        2'd0:    nr_next_s = 4'd10;
                        2'd1:    nr_next_s = 4'd12;
                        default: nr_next_s = 4'd14;
                    endcase
                end else begin
                    fsm_next_s = ST_IDLE;
                end
            end
            ST_ARK: begin
                state_next_s = state_r ^ rk_data;
                step_next_s  = 4'd0;
                if (round_r == nr_r) begin
                    fsm_next_s = ST_DONE;
                end else begin
                    round_next_s = round_r + 4'd1;
                    fsm_next_s   = ST_SUB;
                end
            end
            ST_SUB: begin
                for (int l = 0; l < LANES; l++) begin
                    state_next_s[127 - 8*(lane_base_s + l) -: 8] = sub_out_s[l];
                end
                if (step_r == STEP_LAST) begin
                    step_next_s = 4'd0;
                    fsm_next_s  = ST_SR;
                end else begin
                    step_next_s = step_r + 4'd1;
                end
            end
            ST_SR: begin
                state_next_s = shift_rows(state_r);
                step_next_s  = 4'd0;
                if (round_r == nr_r) begin
                    fsm_next_s = ST_ARK;
                end else begin
                    fsm_next_s = ST_MC;
                end
            end
            ST_MC: begin
                state_next_s[127 - 32*mc_col_s -: 32] = mix_column(state_r[127 - 32*mc_col_s -: 32]);
                if (step_r == 4'd3) begin
                    step_next_s = 4'd0;
                    fsm_next_s  = ST_ARK;
                end else begin
                    step_next_s = step_r + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_next_s   = ST_IDLE;
                    round_next_s = 4'd0;
                end else begin
                    fsm_next_s = ST_DONE;
                end
            end
            default: begin
                fsm_next_s   = ST_IDLE;
                round_next_s = 4'd0;
                step_next_s  = 4'd0;
            end
        endcase
    end

    // State, counters and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r       <= ST_IDLE;
            state_r     <= 128'd0;
            round_r     <= 4'd0;
            nr_r        <= 4'd0;
            step_r      <= 4'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            fsm_r       <= fsm_next_s;
            state_r     <= state_next_s;
            round_r     <= round_next_s;
            nr_r        <= nr_next_s;
            step_r      <= step_next_s;
            in_ready_r  <= (fsm_next_s == ST_IDLE);
            out_valid_r <= (fsm_next_s == ST_DONE);
            busy_r      <= (fsm_next_s != ST_IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_text  = state_r;
    assign rk_idx    = round_r;
    assign cur_round = round_r;

endmodule

// File: doc/aes_round_engine.md
Name: aes_round_engine

Overview:
Self-sequenced AES encryption datapath that runs a full 128-bit block cipher pass (AES-128/192/256) behind valid/ready handshakes.
- Sequencing is internal; no external FSM, round or byte counters are needed.
- SubBytes throughput is parametrised through LANES parallel S-box instances. Reuses the existing SubBytes, shift_rows and mix_columns cells.
- Round keys are fetched from an external key store (key expansion is out of scope) through an index/data port.

Parameters:
LANES, 4, S-box instances (bytes substituted per cycle); legal values 1, 2, 4, 8, 16; any other value is an elaboration error.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  plaintext offered
in_ready  out  1  engine can accept; high only in IDLE
in_text  in  128  plaintext; byte 0 = bits [127:120], column-major AES order
in_key_mode  in  2  0=AES-128 (Nr=10), 1=AES-192 (Nr=12), 2 or 3=AES-256 (Nr=14)
rk_idx  out  4  round-key index requested (0..Nr)
rk_data  in  128  round key for rk_idx; key store has fixed 1-cycle read latency
out_valid  out  1  ciphertext valid
out_ready  in  1  consumer takes ciphertext
out_text  out  128  ciphertext, same byte order as in_text
busy  out  1  high in every state except IDLE
cur_round  out  4  current round counter, debug

Behaviour:
- Reset (async, any time including mid-block): FSM=IDLE, state register=0, round=0, byte step=0, out_valid=0, busy=0, in_ready=1 once rst deasserts. The block in flight is discarded.
- Derived value: S = 16/LANES SubBytes cycles per round.
- FSM states and durations:
  - IDLE: in_ready=1. When in_valid&in_ready, state<=in_text, Nr is latched from in_key_mode, then go to ARK.
  - ARK (1 cycle): state<=state^rk_data. If round==Nr go to DONE; otherwise round<=round+1 and go to SUB.
  - SUB (S cycles): on step k, bytes k*LANES..k*LANES+LANES-1 are replaced by their S-box outputs. After step S-1, go to SR.
  - SR (1 cycle): state<=shift_rows(state). If round==Nr go to ARK (final round has no MixColumns); otherwise go to MC.
  - MC (4 cycles): on cycle c, column c (bits [127-32c -: 32]) <= mix_columns(column c). Then go to ARK.
  - DONE: out_valid=1 and out_text=state, both held stable until out_ready. On the edge where out_valid&out_ready, go to IDLE and round<=0.
- rk_idx = round at all times. Round stays 0 in IDLE, and every ARK is at least 2 cycles after the last round update, so the 1-cycle key store always returns the correct key.
- in_key_mode changes after accept are ignored. in_ready=0 in DONE, so accepting a new block in the handoff cycle is impossible; the earliest new accept is the cycle after the handoff.
- Latency from accept edge to first cycle with out_valid=1: 1 + (Nr-1)*(S+6) + (S+2) cycles.
  - Nr=10, LANES=1: 217.
  - Nr=10, LANES=16: 67.
  - Nr=14, LANES=4: 137.
- out_ready held low indefinitely: engine stalls in DONE with out_text frozen. out_ready high before out_valid has no effect.
- in_valid dropping without a handshake: no effect.

Test Plan:
1. AES-128, LANES=4, mode 0: in_text=00112233445566778899aabbccddeeff, round keys from bench model of key 000102…0f -> out_text=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid rises exactly 1+9*10+6=97 cycles after accept.
2. AES-192 (mode 1) and AES-256 (mode 3), same plaintext, keys 00…17 and 00…1f -> dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089; rk_idx sequence observed 0..12 and 0..14 respectively.
3. Sweep LANES in {1,2,8,16} with vector 1 -> identical ciphertext; latencies 217, 137, 77, 67.
4. Backpressure: hold out_ready=0 for 50 cycles after out_valid -> out_text stable, in_ready=0, busy=1. Pulse out_ready -> in_ready=1 next cycle; back-to-back second block is correct.
5. Assert rst for 1 cycle mid-SUB of round 5 -> out_valid=0, in_ready=1, busy=0, cur_round=0 immediately (async). A following fresh block produces the correct ciphertext.
6. Toggle in_key_mode 0->2 during a mode-0 run -> run still completes in 10 rounds with the AES-128 result.
